dfa_match_engine: RTL
=====================

DFA_MATCH_ENGINE -- requirements
Module: dfa_match_engine

Interface
REQ-001 SHALL have parameter STATE_W, default 11, width of DFA state index.
REQ-002 SHALL have parameter CLASS_W, default 4, width of character-class index (2**CLASS_W classes).
REQ-003 SHALL have parameter NUM_STATES, default 16, number of implemented DFA states (at most 2**STATE_W).
REQ-004 SHALL have parameter NUM_CTX, default 4, number of independent flow contexts.
REQ-005 SHALL have one clock and an asynchronous active-low reset, named clk and rst_n.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 char_in  input  8  character to scan.
REQ-009 char_in_vld  input  1  character present.
REQ-010 char_in_rdy  output  1  engine accepts character this cycle.
REQ-011 ctx_sel  input  clog2(NUM_CTX)  context for char_in, state_in and state_out.
REQ-012 state_in  input  STATE_W  state overwrite value.
REQ-013 state_in_vld  input  1  overwrite state of ctx_sel.
REQ-014 state_out  output  STATE_W  current state of ctx_sel, combinational.
REQ-015 cfg_wr_en  input  1  table write strobe.
REQ-016 cfg_sel  input  2  target table: 0 char map, 1 transition, 2 accept, 3 reserved.
REQ-017 cfg_addr  input  STATE_W+CLASS_W  table address; transition address is {state, class}.
REQ-018 cfg_data  input  STATE_W  write data, low bits used.
REQ-019 accept_out  output  1  registered match pulse.
REQ-020 accept_ctx  output  clog2(NUM_CTX)  context of accept_out.

Function
REQ-021 A character SHALL be consumed when char_in_vld and char_in_rdy are both high.
REQ-022 char_in_rdy SHALL be low when cfg_wr_en or state_in_vld is high, and high otherwise.
REQ-023 On consumption: class = charmap[char_in]; next = trans[state[ctx_sel]][class]; state[ctx_sel] <= next at the same edge.
REQ-024 accept_out SHALL be high exactly one cycle after consumption when accept[next] is 1; accept_ctx SHALL then hold that cycle's ctx_sel.
REQ-025 Back-to-back characters on the same context SHALL use the just-updated state, with no bubble; throughput SHALL be one character per cycle.
REQ-026 state_in_vld SHALL write state_in into state[ctx_sel], take priority over characters and produce no accept pulse.
REQ-027 cfg_wr_en SHALL take priority over state_in_vld; a state overwrite presented in the same cycle is dropped.
REQ-028 A state index at or above NUM_STATES (from state_in or the table) SHALL transition to 0 and never accept.
REQ-029 A cfg write with cfg_sel=3, or an out-of-range address, SHALL be ignored.
REQ-030 A table write SHALL take effect for characters consumed from the next cycle onward.
REQ-031 Other contexts' states SHALL be unaffected by any operation on ctx_sel.

Reset
REQ-032 rst_n low SHALL immediately clear: all context states to 0, accept table to all 0, accept_out to 0, accept_ctx to 0.
REQ-033 The char map and transition tables SHALL NOT be reset; they must be reloaded by software after power-up.
REQ-034 Reset asserted mid-stream SHALL discard any pending accept; the first character after release sees state 0.

Configuration
REQ-035 Macro DFA_MATCH_CNT_EN SHALL, when defined, add output match_cnt (16 bits), the count for ctx_sel.
- Counts one per accept_out pulse for that context.
- Saturates at 16'hFFFF.
- Cleared by reset and by state_in_vld on that context.
REQ-036 Without DFA_MATCH_CNT_EN, the match_cnt port and counters SHALL be absent and all other behaviour is identical.

Structure
REQ-037 A shared package dfa_pkg SHALL hold:
- cfg_sel encodings: CFG_CHARMAP, CFG_TRANS, CFG_ACCEPT.
- state_t and class_t typedefs.
- Counter width constant MATCH_CNT_W = 16.
REQ-038 Table storage SHALL be one sub-module, dfa_tables: write port plus combinational char-map, transition and accept lookups. Context state registers and the handshake SHALL stay in the top module.

Verification
REQ-039 Load the "USER" pattern (U/u->1, S/s->2, E/e->3, R/r->4, trans 0-1-2-3-4, accept[4]=1); stream "xuSeR" on ctx 0 -> a single accept_out pulse, one cycle after 'R', accept_ctx=0.
REQ-040 Interleave "US" on ctx 0 and "ER" on ctx 1, then "ER" on ctx 0 -> no accept on ctx 1; accept on ctx 0 after final 'R'.
REQ-041 Hold cfg_wr_en with char_in_vld high -> char_in_rdy=0 and state unchanged; the character is consumed the cycle after cfg_wr_en drops.
REQ-042 Apply state_in=3 with state_in_vld on ctx 2, then 'R' -> accept_out=1, accept_ctx=2; set state_in=20 -> next state 0, no accept.
REQ-043 With DFA_MATCH_CNT_EN, drive 65537 accepting characters on ctx 0 -> match_cnt=16'hFFFF; pulse rst_n low mid-stream -> state_out=0, accept_out=0, match_cnt=0 immediately.

Source files
------------

// File: rtl/dfa_pkg.sv
// rtl/dfa_pkg.sv - shared types and encodings for the DFA match engine
// Holds the cfg_sel encodings, default-width state/class typedefs and the
// match counter width used by the DFA_MATCH_CNT_EN build.
package dfa_pkg;
  localparam int DFA_STATE_W = 11;
  localparam int DFA_CLASS_W = 4;
  localparam int MATCH_CNT_W = 16;

  typedef enum logic [1:0] {
    CFG_CHARMAP = 2'd0,
    CFG_TRANS   = 2'd1,
    CFG_ACCEPT  = 2'd2,
    CFG_RSVD    = 2'd3
  } cfg_sel_t;

  typedef logic [DFA_STATE_W-1:0] state_t;
  typedef logic [DFA_CLASS_W-1:0] class_t;
endpackage

// File: rtl/dfa_tables.sv
// rtl/dfa_tables.sv - char map, transition and accept tables with lookups
// Ports:
//   clk, rst_n          clock, async active-low reset (accept table only)
//   wr_en/wr_sel/wr_addr/wr_data  table write port
//   char_in, cur_state  lookup inputs
//   next_state          trans[cur_state][charmap[char_in]], 0 if cur_state out of range
//   next_accept         accept[next_state], 0 if next_state out of range
module dfa_tables
  import dfa_pkg::*;
#(
  parameter int STATE_W    = 11,
  parameter int CLASS_W    = 4,
  parameter int NUM_STATES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [1:0]                 wr_sel,
  input  logic [STATE_W+CLASS_W-1:0] wr_addr,
  input  logic [STATE_W-1:0]         wr_data,
  input  logic [7:0]                 char_in,
  input  logic [STATE_W-1:0]         cur_state,
  output logic [STATE_W-1:0]         next_state,
  output logic                       next_accept
);
  localparam int ADDR_W = STATE_W + CLASS_W;
  localparam int NCLASS = 2 ** CLASS_W;
  localparam int SIDX_W = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam logic [STATE_W:0] NS_S = (STATE_W+1)'(NUM_STATES);
  localparam logic [ADDR_W:0]  NS_A = (ADDR_W+1)'(NUM_STATES);

  // char map and transition table are deliberately not reset
  logic [CLASS_W-1:0]    charmap [256];
  logic [STATE_W-1:0]    trans   [NUM_STATES][NCLASS];
  logic [NUM_STATES-1:0] accept;

  logic [STATE_W-1:0] wr_st;
  logic [CLASS_W-1:0] wr_cls;
  logic               cm_ok, tr_ok, ac_ok;

  assign wr_st  = wr_addr[ADDR_W-1:CLASS_W];
  assign wr_cls = wr_addr[CLASS_W-1:0];
  assign cm_ok  = (wr_addr[ADDR_W-1:8] == '0);
  assign tr_ok  = ({1'b0, wr_st} < NS_S);
  assign ac_ok  = ({1'b0, wr_addr} < NS_A);

  always_ff @(posedge clk) begin
    if (wr_en && wr_sel == CFG_CHARMAP && cm_ok)
      charmap[wr_addr[7:0]] <= wr_data[CLASS_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_sel == CFG_TRANS && tr_ok)
      trans[wr_st[SIDX_W-1:0]][wr_cls] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      accept <= '0;
    else if (wr_en && wr_sel == CFG_ACCEPT && ac_ok)
      accept[wr_addr[SIDX_W-1:0]] <= wr_data[0];
  end

  logic [CLASS_W-1:0] cls;
  logic               cur_ok, nxt_ok;

  assign cls         = charmap[char_in];
  // an out-of-range state (from software or a bad table entry) falls back to 0
  assign cur_ok      = ({1'b0, cur_state} < NS_S);
  assign next_state  = cur_ok ? trans[cur_state[SIDX_W-1:0]][cls] : '0;
  assign nxt_ok      = ({1'b0, next_state} < NS_S);
  assign next_accept = nxt_ok & accept[next_state[SIDX_W-1:0]];
endmodule

// File: rtl/dfa_match_engine.sv
// rtl/dfa_match_engine.sv - multi-context DFA character scanner
// Optional feature macro: DFA_MATCH_CNT_EN adds per-context saturating match_cnt.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   char_in/char_in_vld/char_in_rdy  character stream, one per cycle
//   ctx_sel                       context for char_in, state_in, state_out
//   state_in/state_in_vld         state overwrite for ctx_sel
//   state_out                     current state of ctx_sel (combinational)
//   cfg_wr_en/cfg_sel/cfg_addr/cfg_data  table write port
//   accept_out/accept_ctx         registered match pulse and its context
//   match_cnt                     (DFA_MATCH_CNT_EN) match count of ctx_sel
module dfa_match_engine
  import dfa_pkg::*;
#(
  parameter int STATE_W    = 11,
  parameter int CLASS_W    = 4,
  parameter int NUM_STATES = 16,
  parameter int NUM_CTX    = 4,
  localparam int CTX_W     = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 char_in,
  input  logic                       char_in_vld,
  output logic                       char_in_rdy,
  input  logic [CTX_W-1:0]           ctx_sel,
  input  logic [STATE_W-1:0]         state_in,
  input  logic                       state_in_vld,
  output logic [STATE_W-1:0]         state_out,
  input  logic                       cfg_wr_en,
  input  logic [1:0]                 cfg_sel,
  input  logic [STATE_W+CLASS_W-1:0] cfg_addr,
  input  logic [STATE_W-1:0]         cfg_data,
  output logic                       accept_out,
  output logic [CTX_W-1:0]           accept_ctx
`ifdef DFA_MATCH_CNT_EN
  ,
  output logic [MATCH_CNT_W-1:0]     match_cnt
`endif
);
  logic [STATE_W-1:0] state_q [NUM_CTX];
  logic [STATE_W-1:0] cur_state, next_state;
  logic               next_accept, consume, ovr;

  // cfg writes beat overwrites, overwrites beat characters
  assign char_in_rdy = ~(cfg_wr_en | state_in_vld);
  assign consume     = char_in_vld & char_in_rdy;
  assign ovr         = state_in_vld & ~cfg_wr_en;
  assign cur_state   = state_q[ctx_sel];
  assign state_out   = cur_state;

  dfa_tables #(
    .STATE_W    (STATE_W),
    .CLASS_W    (CLASS_W),
    .NUM_STATES (NUM_STATES)
  ) u_tables (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (cfg_wr_en),
    .wr_sel      (cfg_sel),
    .wr_addr     (cfg_addr),
    .wr_data     (cfg_data),
    .char_in     (char_in),
    .cur_state   (cur_state),
    .next_state  (next_state),
    .next_accept (next_accept)
  );

  // lookup is fully combinational off the live state register, so
  // back-to-back characters on one context need no forwarding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) state_q[i] <= '0;
      accept_out <= 1'b0;
      accept_ctx <= '0;
    end else begin
      accept_out <= consume & next_accept;
      if (consume) accept_ctx <= ctx_sel;
      if (ovr)
        state_q[ctx_sel] <= state_in;
      else if (consume)
        state_q[ctx_sel] <= next_state;
    end
  end

`ifdef DFA_MATCH_CNT_EN
  logic [MATCH_CNT_W-1:0] cnt_q [NUM_CTX];

  // counts registered pulses, so a count lands one cycle after accept_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (ovr && ctx_sel == CTX_W'(i))
          cnt_q[i] <= '0;
        else if (accept_out && accept_ctx == CTX_W'(i) && cnt_q[i] != '1)
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign match_cnt = cnt_q[ctx_sel];
`endif
endmodule
